// File: rtl/riscv_pkg.sv
// Shared memory-stage definitions: load/store funct3 encodings, the access FSM
// state type and the alignment rule used by both the EX-side and MEM-side logic.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    RUN    = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  // Halfwords need an even offset, words a zero offset; bytes never fault.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LH, F3_LHU: is_misaligned = off[0];
      F3_LW:         is_misaligned = (off != 2'b00);
      default:       is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane selection and sign/zero extension of a 32-bit bus word.
module load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  import riscv_pkg::*;

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed lane, then extend according to the load type.
  always_comb begin
    byte_s = rdata[{off, 3'b000} +: 8];
    half_s = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   data = {{24{byte_s[7]}}, byte_s};
      F3_LH:   data = {{16{half_s[15]}}, half_s};
      F3_LBU:  data = {24'h00_0000, byte_s};
      F3_LHU:  data = {16'h0000, half_s};
      F3_LW:   data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RISC-V MEM pipeline stage: EX/MEM and MEM/WB registers, a RUN/ACCESS bus FSM
// that stalls the pipeline until the data bus answers, and store lane steering.
module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] alu_result_EX,
  input  logic [XLEN-1:0] store_data_EX,
  input  logic [4:0]      rd_EX,
  input  logic            valid_EX,
  input  logic            reg_write_EX,
  input  logic            mem_read_EX,
  input  logic            mem_write_EX,
  input  logic [2:0]      funct3_EX,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ready,
  output logic [XLEN-1:0] alu_result_MEM,
  output logic            stall,
  output logic            misalign_exc,
  output logic [XLEN-1:0] wb_data_WB,
  output logic [4:0]      rd_WB,
  output logic            reg_write_WB,
  output logic            valid_WB
);
  import riscv_pkg::*;

  logic [XLEN-1:0] alu_r;
  logic [XLEN-1:0] sdata_r;
  logic [4:0]      rd_r;
  logic [2:0]      f3_r;
  logic            valid_r;
  logic            regw_r;
  logic            mread_r;
  logic            mwrite_r;
  mem_state_t      state_r;
  mem_state_t      state_nxt_s;

  logic [1:0]      off_s;
  logic            mem_op_s;
  logic            misalign_s;
  logic            ex_access_s;
  logic            stall_s;
  logic [XLEN-1:0] load_data_s;

  assign off_s       = alu_r[1:0];
  assign mem_op_s    = valid_r & (mread_r | mwrite_r);
  assign misalign_s  = mem_op_s & is_misaligned(f3_r, off_s);
  // Only an aligned, valid memory op being captured opens a bus access.
  assign ex_access_s = valid_EX & (mem_read_EX | mem_write_EX)
                     & ~is_misaligned(funct3_EX, alu_result_EX[1:0]);
  assign stall_s     = (state_r == ACCESS) & ~dmem_ready;

  assign stall          = stall_s;
  assign misalign_exc   = misalign_s;
  assign alu_result_MEM = alu_r;
  assign dmem_addr      = {alu_r[XLEN-1:2], 2'b00};

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .off    (off_s),
    .funct3 (f3_r),
    .data   (load_data_s)
  );

  // Bus request, byte enables and replicated store data while in ACCESS.
  always_comb begin
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_be    = 4'b0000;
    dmem_wdata = {XLEN{1'b0}};
    if (state_r == ACCESS) begin
      dmem_req = 1'b1;
      dmem_we  = mwrite_r;
      if (mwrite_r) begin
        case (f3_r)
          F3_SB: begin
            dmem_be    = 4'b0001 << off_s;
            dmem_wdata = {4{sdata_r[7:0]}};
          end
          F3_SH: begin
            dmem_be    = off_s[1] ? 4'b1100 : 4'b0011;
            dmem_wdata = {2{sdata_r[15:0]}};
          end
          F3_SW: begin
            dmem_be    = 4'b1111;
            dmem_wdata = sdata_r;
          end
          default: begin
            dmem_be    = 4'b1111;
            dmem_wdata = sdata_r;
          end
        endcase
      end else begin
        dmem_be = 4'b1111;
      end
    end else begin
      dmem_req = 1'b0;
    end
  end

  // Next state: decided by the instruction captured on the next unstalled edge.
  always_comb begin
    state_nxt_s = state_r;
    if (!stall_s) begin
      state_nxt_s = ex_access_s ? ACCESS : RUN;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // EX/MEM and MEM/WB pipeline registers, both frozen while the bus stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_r        <= {XLEN{1'b0}};
      sdata_r      <= {XLEN{1'b0}};
      rd_r         <= 5'd0;
      f3_r         <= 3'b000;
      valid_r      <= 1'b0;
      regw_r       <= 1'b0;
      mread_r      <= 1'b0;
      mwrite_r     <= 1'b0;
      wb_data_WB   <= {XLEN{1'b0}};
      rd_WB        <= 5'd0;
      reg_write_WB <= 1'b0;
      valid_WB     <= 1'b0;
    end else if (!stall_s) begin
      alu_r        <= alu_result_EX;
      sdata_r      <= store_data_EX;
      rd_r         <= rd_EX;
      f3_r         <= funct3_EX;
      valid_r      <= valid_EX;
      regw_r       <= reg_write_EX;
      mread_r      <= mem_read_EX;
      mwrite_r     <= mem_write_EX;
      wb_data_WB   <= (mem_op_s & mread_r & ~misalign_s) ? load_data_s : alu_r;
      rd_WB        <= rd_r;
      reg_write_WB <= valid_r & regw_r & ~misalign_s;
      valid_WB     <= valid_r;
    end else begin
      alu_r        <= alu_r;
      wb_data_WB   <= wb_data_WB;
    end
  end

endmodule
